ram: RTL and testbench
======================

Name: ram

Overview:
- True dual-port synchronous RAM: two independent ports (A, B) share one storage array of 2^ADDR_WIDTH words of DATA_WIDTH bits.
- Both ports read and write on the single clock, with registered read outputs.
- Used as general-purpose byte storage; a client can move 16 bits per cycle by driving adjacent addresses on A and B.

Parameters:
- DATA_WIDTH, 8, word width in bits for data_a/data_b/q_a/q_b.
- ADDR_WIDTH, 10, address width; depth = 2^ADDR_WIDTH words (1024 by default).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- we_a  input  1  port A write enable.
- we_b  input  1  port B write enable.
- data_a  input  DATA_WIDTH  port A write data.
- data_b  input  DATA_WIDTH  port B write data.
- addr_a  input  ADDR_WIDTH  port A address.
- addr_b  input  ADDR_WIDTH  port B address.
- q_a  output  DATA_WIDTH  port A registered read data.
- q_b  output  DATA_WIDTH  port B registered read data.

Behaviour:
- Reset: rst_n low clears q_a and q_b to 0 immediately, without waiting for a clock edge. Memory contents are not cleared and are undefined until written. While rst_n is low, writes are ignored.
- Write, each port independently: on a rising clk with we_x=1, mem[addr_x] <= data_x.
- Read, each port independently: on a rising clk with we_x=0, q_x <= mem[addr_x]. Latency is 1 cycle: data appears after the edge that samples the address. q_x holds its value between edges.
- Same-port read-during-write is write-first: when we_x=1, q_x <= data_x on that edge.
- Cross-port, same address, one writes and one reads: the reading port returns the old contents. The new value is visible from the next cycle.
- Both ports write the same address on the same edge: port B's data is stored. Each port's q follows its own write-first rule.
- Ports on different addresses are fully independent; both can read and/or write in the same cycle.
- Addresses use the full range 0 to 2^ADDR_WIDTH-1; there is no wrap or bounds logic. An external address+1 that overflows simply wraps modulo 2^ADDR_WIDTH.
- Reset mid-operation: an edge coincident with rst_n low performs no write. q_x stays 0 until the first rising edge after rst_n deasserts.

Test Plan:
- Reset: drive rst_n=0 with q_a=q_b nonzero from a prior read -> q_a=q_b=0x00 immediately; after release, a read of a written address returns the stored data.
- Block write/read:
  - Write the 35-byte ASCII string "This RAM module can read and write." (0x546869732052414d...77726974652e) to addresses 0..34, using paired A/B writes to addr, addr+1 and single-port writes for the tail.
  - Read back using mixed single-port and paired reads at odd offsets.
  - -> all 35 bytes match; e.g. mem[0]=0x54, mem[3]=0x73, mem[34]=0x2E.
- Dual independent access: port A writes 0xAA to addr 5 while port B reads addr 6 (holding 0x55) -> q_b=0x55 next cycle; a subsequent A read of 5 gives 0xAA.
- Read-during-write:
  - A writes 0x3C to addr 10 (previously 0x11) while B reads addr 10 -> q_a=0x3C (write-first), q_b=0x11 (old data).
  - The next B read of 10 -> 0x3C.
- Write collision: A writes 0x01 and B writes 0x02 to addr 20 on the same edge -> a later read of addr 20 on either port returns 0x02.
- Boundary addresses: write 0xFF to addr 1023 via B and 0x7E to addr 0 via A -> reads return 0xFF and 0x7E, with no aliasing between them.

Source files
------------

// File: rtl/ram_if.sv
// -----------------------------------------------------------------------------
// ram_if : bus bundle for the true dual-port RAM.
//
// Carries both ports' request and response signals:
//   we_a / we_b      write enables, one per port
//   data_a / data_b  write data, one per port
//   addr_a / addr_b  word addresses, one per port
//   q_a / q_b        registered read data, one per port
//
// The master modport drives requests and receives read data. The slave
// modport (the RAM) does the opposite. clk and rst_n are not part of the
// bundle; they stay plain ports on the RAM.
// -----------------------------------------------------------------------------
interface ram_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 10
);

  logic                  we_a;
  logic                  we_b;
  logic [DATA_WIDTH-1:0] data_a;
  logic [DATA_WIDTH-1:0] data_b;
  logic [ADDR_WIDTH-1:0] addr_a;
  logic [ADDR_WIDTH-1:0] addr_b;
  logic [DATA_WIDTH-1:0] q_a;
  logic [DATA_WIDTH-1:0] q_b;

  modport master (
    output we_a, we_b, data_a, data_b, addr_a, addr_b,
    input  q_a, q_b
  );

  modport slave (
    input  we_a, we_b, data_a, data_b, addr_a, addr_b,
    output q_a, q_b
  );

endinterface : ram_if

// File: rtl/ram.sv
// -----------------------------------------------------------------------------
// ram : true dual-port synchronous RAM with registered read outputs.
//
// Two independent ports, A and B, share one array of 2**ADDR_WIDTH words of
// DATA_WIDTH bits. Both ports work on the single clock.
//
// Ports:
//   clk    rising-edge clock for all state
//   rst_n  asynchronous active-low reset. It clears q_a/q_b and blocks writes.
//   bus    ram_if.slave: we_a/we_b, data_a/data_b, addr_a/addr_b in,
//          q_a/q_b out
//
// Behaviour summary:
//   - The read latency is one cycle. q_x holds its value between edges.
//   - A write on a port also updates that port's q on the same edge. The
//     port returns the data it is writing.
//   - A read on the other port at the same address returns the old word.
//   - When both ports write one address on the same edge, port B's data is
//     stored.
// -----------------------------------------------------------------------------
module ram #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 10
) (
  input  logic   clk,
  input  logic   rst_n,
  ram_if.slave   bus
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef logic [DATA_WIDTH-1:0] word_t;

  word_t mem [0:DEPTH-1];

  word_t q_a_d, q_a_q;
  word_t q_b_d, q_b_q;

  // ---------------------------------------------------------------------------
  // Read data selection. A writing port returns the data it is writing. A
  // reading port returns the array contents as they were before this edge.
  // Cross-port reads at the same address therefore see the old word.
  // ---------------------------------------------------------------------------
  always_comb begin
    q_a_d = bus.we_a ? bus.data_a : mem[bus.addr_a];
    q_b_d = bus.we_b ? bus.data_b : mem[bus.addr_b];
  end

  // ---------------------------------------------------------------------------
  // Storage array.
  // NOTE: the array is deliberately left out of reset. Resetting every word
  // would stop the array from mapping onto block RAM. rst_n is only sampled
  // here to suppress writes while it is low.
  //
  // The port B write comes after the port A write in this block. On an
  // address collision, port B's data is therefore the value that lands.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (bus.we_a) mem[bus.addr_a] <= bus.data_a;
      if (bus.we_b) mem[bus.addr_b] <= bus.data_b;
    end
  end

  // ---------------------------------------------------------------------------
  // Output registers. Reset clears them at once, without waiting for a clock
  // edge. They stay zero until the first rising edge after release.
  // NOTE: sequential state uses non-blocking assignments only. Every flop
  // then samples pre-edge values, and the cross-port old-data behaviour
  // depends on that.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_a_q <= '0;
      q_b_q <= '0;
    end else begin
      q_a_q <= q_a_d;
      q_b_q <= q_b_d;
    end
  end

  assign bus.q_a = q_a_q;
  assign bus.q_b = q_b_q;

endmodule : ram

// File: tb/tb_ram.sv
// -----------------------------------------------------------------------------
// tb_ram : directed testbench for the dual-port RAM.
//
// The bench drives inputs on the falling edge. Each step queues the expected
// read data for every port it checks, and those entries are popped and
// compared 1 ns after the next rising edge.
// -----------------------------------------------------------------------------
module tb_ram;

  localparam int DW = 8;
  localparam int AW = 10;
  localparam string MSG = "This RAM module can read and write.";

  logic clk = 1'b0;
  logic rst_n;

  ram_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  ram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    string        tag;
    bit           port_b;
    logic [DW-1:0] exp;
  } sb_entry_t;

  sb_entry_t sb_q [$];

  int tests_run = 0;
  int tests_failed = 0;

  task automatic check(input string tag, input logic [DW-1:0] obs,
                       input logic [DW-1:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  // One clock step. chk_x queues an expected q_x value for the edge of this
  // step. The queued entries are compared right after that edge.
  task automatic step(input string tag,
                      input logic wa, input logic [AW-1:0] aa, input logic [DW-1:0] da,
                      input logic chk_a, input logic [DW-1:0] xa,
                      input logic wb, input logic [AW-1:0] ab, input logic [DW-1:0] db,
                      input logic chk_b, input logic [DW-1:0] xb);
    sb_entry_t e;
    @(negedge clk);
    bus.we_a = wa; bus.addr_a = aa; bus.data_a = da;
    bus.we_b = wb; bus.addr_b = ab; bus.data_b = db;
    if (chk_a) begin e.tag = {tag, "/A"}; e.port_b = 1'b0; e.exp = xa; sb_q.push_back(e); end
    if (chk_b) begin e.tag = {tag, "/B"}; e.port_b = 1'b1; e.exp = xb; sb_q.push_back(e); end
    @(posedge clk);
    #1;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check(e.tag, e.port_b ? bus.q_b : bus.q_a, e.exp);
    end
    bus.we_a = 1'b0;
    bus.we_b = 1'b0;
  endtask

  function automatic logic [DW-1:0] msg_byte(input int i);
    return MSG[i];
  endfunction

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    bus.we_a = 1'b0; bus.we_b = 1'b0;
    bus.addr_a = '0; bus.addr_b = '0;
    bus.data_a = '0; bus.data_b = '0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("reset_q_a", bus.q_a, 8'h00);
    check("reset_q_b", bus.q_b, 8'h00);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Block write: pairs A=addr, B=addr+1 for 0..31, then a single-port tail.
    for (int i = 0; i < 32; i += 2)
      step("wr_pair", 1'b1, AW'(i), msg_byte(i), 1'b1, msg_byte(i),
                      1'b1, AW'(i + 1), msg_byte(i + 1), 1'b1, msg_byte(i + 1));
    step("wr_tail32", 1'b1, 10'd32, msg_byte(32), 1'b0, 8'h00, 1'b0, 10'd0, 8'h00, 1'b0, 8'h00);
    step("wr_tail33", 1'b0, 10'd0, 8'h00, 1'b0, 8'h00, 1'b1, 10'd33, msg_byte(33), 1'b0, 8'h00);
    step("wr_tail34", 1'b1, 10'd34, msg_byte(34), 1'b0, 8'h00, 1'b0, 10'd0, 8'h00, 1'b0, 8'h00);

    // Readback: single A at 0, pairs at odd offsets, then single B and A.
    step("rd_0", 1'b0, 10'd0, 8'h00, 1'b1, 8'h54, 1'b0, 10'd0, 8'h00, 1'b0, 8'h00);
    for (int i = 1; i < 33; i += 2)
      step("rd_pair", 1'b0, AW'(i), 8'h00, 1'b1, msg_byte(i),
                      1'b0, AW'(i + 1), 8'h00, 1'b1, msg_byte(i + 1));
    step("rd_3_33", 1'b0, 10'd3, 8'h00, 1'b1, 8'h73, 1'b0, 10'd33, 8'h00, 1'b1, msg_byte(33));
    step("rd_34", 1'b0, 10'd34, 8'h00, 1'b1, 8'h2E, 1'b0, 10'd34, 8'h00, 1'b1, 8'h2E);

    // Mid-run reset: q clears at once, and writes during reset are dropped.
    step("pre_rst", 1'b0, 10'd0, 8'h00, 1'b1, 8'h54, 1'b0, 10'd1, 8'h00, 1'b1, 8'h68);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_q_a", bus.q_a, 8'h00);
    check("midrst_q_b", bus.q_b, 8'h00);
    @(negedge clk);
    bus.we_a = 1'b1; bus.addr_a = 10'd0; bus.data_a = 8'hEE;
    bus.we_b = 1'b1; bus.addr_b = 10'd1; bus.data_b = 8'hDD;
    @(posedge clk);
    #1;
    check("rst_hold_q_a", bus.q_a, 8'h00);
    check("rst_hold_q_b", bus.q_b, 8'h00);
    @(negedge clk);
    bus.we_a = 1'b0; bus.we_b = 1'b0;
    rst_n = 1'b1;
    step("post_rst", 1'b0, 10'd0, 8'h00, 1'b1, 8'h54, 1'b0, 10'd1, 8'h00, 1'b1, 8'h68);

    // Dual independent access.
    step("dual_init", 1'b0, 10'd0, 8'h00, 1'b0, 8'h00, 1'b1, 10'd6, 8'h55, 1'b1, 8'h55);
    step("dual", 1'b1, 10'd5, 8'hAA, 1'b1, 8'hAA, 1'b0, 10'd6, 8'h00, 1'b1, 8'h55);
    step("dual_rd5", 1'b0, 10'd5, 8'h00, 1'b1, 8'hAA, 1'b0, 10'd7, 8'h00, 1'b0, 8'h00);

    // Read-during-write: write-first on A, old data on B.
    step("rdw_init", 1'b1, 10'd10, 8'h11, 1'b0, 8'h00, 1'b0, 10'd0, 8'h00, 1'b0, 8'h00);
    step("rdw", 1'b1, 10'd10, 8'h3C, 1'b1, 8'h3C, 1'b0, 10'd10, 8'h00, 1'b1, 8'h11);
    step("rdw_next", 1'b0, 10'd0, 8'h00, 1'b0, 8'h00, 1'b0, 10'd10, 8'h00, 1'b1, 8'h3C);

    // Write collision: port B's data is stored.
    step("coll", 1'b1, 10'd20, 8'h01, 1'b1, 8'h01, 1'b1, 10'd20, 8'h02, 1'b1, 8'h02);
    step("coll_rd", 1'b0, 10'd20, 8'h00, 1'b1, 8'h02, 1'b0, 10'd20, 8'h00, 1'b1, 8'h02);

    // Boundary addresses, with no aliasing between 0 and 1023.
    step("bnd_wr", 1'b1, 10'd0, 8'h7E, 1'b1, 8'h7E, 1'b1, 10'd1023, 8'hFF, 1'b1, 8'hFF);
    step("bnd_rd", 1'b0, 10'd1023, 8'h00, 1'b1, 8'hFF, 1'b0, 10'd0, 8'h00, 1'b1, 8'h7E);
    step("bnd_rd2", 1'b0, 10'd0, 8'h00, 1'b1, 8'h7E, 1'b0, 10'd1023, 8'h00, 1'b1, 8'hFF);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule : tb_ram
